// File: rtl/module_8_64_if.sv
// -----------------------------------------------------------------------------
// module_8_64_if
// Purpose : groups the byte-input side and the word-output side of the
//           8-to-64 packer into one bundle.
// Signals : strobe_in/input_data/data_end  - byte stream into the packer
//           full/overflow                   - back-pressure and sticky drop flag
//           req_data                        - downstream word request
//           ready/strobe_out/data_out/byte_cnt/last_out - word output side
// Modports: master = byte producer / word consumer, slave = packer.
// -----------------------------------------------------------------------------
interface module_8_64_if;
    logic        strobe_in;
    logic [7:0]  input_data;
    logic        data_end;
    logic        full;
    logic        overflow;
    logic        req_data;
    logic        ready;
    logic        strobe_out;
    logic [63:0] data_out;
    logic [3:0]  byte_cnt;
    logic        last_out;

    modport master (
        output strobe_in, input_data, data_end, req_data,
        input  full, overflow, ready, strobe_out, data_out, byte_cnt, last_out
    );

    modport slave (
        input  strobe_in, input_data, data_end, req_data,
        output full, overflow, ready, strobe_out, data_out, byte_cnt, last_out
    );
endinterface

// File: rtl/module_8_64.sv
// -----------------------------------------------------------------------------
// module_8_64
// Purpose : packs a byte stream little-endian into 64-bit words, closing a
//           word on its 8th byte or on data_end, and buffers completed words
//           in a FIFO_DEPTH-entry queue that downstream drains via req_data.
// Ports   : clk      - single clock, posedge
//           reset_n  - asynchronous active-low reset
//           bus      - module_8_64_if.slave (byte input, word output, flags)
// -----------------------------------------------------------------------------
module module_8_64 #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    module_8_64_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = 3;

    // Assembly state
    logic [63:0]      r_asm;
    logic [IDX_W-1:0] r_byte_idx;

    // Word buffer state
    logic [63:0]      r_mem_data [FIFO_DEPTH];
    logic [3:0]       r_mem_cnt  [FIFO_DEPTH];
    logic             r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic             r_full;
    logic             r_overflow;

    // Output registers
    logic             r_strobe_out;
    logic [63:0]      r_data_out;
    logic [3:0]       r_byte_cnt;
    logic             r_last_out;

    // Next-state / combinational
    logic             w_accept;
    logic             w_drop;
    logic             w_pop;
    logic             w_push;
    logic [63:0]      w_word;
    logic [3:0]       w_word_cnt;
    logic [63:0]      w_asm_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ready_nxt;
    logic             w_full_nxt;

    // Next-state logic for assembly and buffer bookkeeping
    always_comb begin
        w_accept    = bus.strobe_in & ~r_full;
        w_drop      = bus.strobe_in & r_full;
        w_pop       = bus.req_data & r_ready;
        // Current byte merged into its lane; earlier lanes already sit in r_asm
        w_word      = r_asm | (64'(bus.input_data) << {r_byte_idx, 3'b000});
        w_word_cnt  = 4'(r_byte_idx) + 4'd1;
        w_push      = w_accept & ((r_byte_idx == 3'd7) | bus.data_end);

        w_asm_nxt   = r_asm;
        w_idx_nxt   = r_byte_idx;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;

        if (w_accept) begin
            if (w_push) begin
                // Clear so the next word starts with zeroed lanes
                w_asm_nxt = 64'd0;
                w_idx_nxt = '0;
            end else begin
                w_asm_nxt = w_word;
                w_idx_nxt = r_byte_idx + IDX_W'(1);
            end
        end

        if (w_push) w_wptr_nxt = r_wptr + PTR_W'(1);
        if (w_pop)  w_rptr_nxt = r_rptr + PTR_W'(1);

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase

        w_ready_nxt = (w_count_nxt != '0);
        w_full_nxt  = (w_count_nxt == CNT_W'(FIFO_DEPTH));
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_asm        <= 64'd0;
            r_byte_idx   <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ready      <= 1'b0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_strobe_out <= 1'b0;
            r_data_out   <= 64'd0;
            r_byte_cnt   <= 4'd0;
            r_last_out   <= 1'b0;
        end else begin
            r_asm        <= w_asm_nxt;
            r_byte_idx   <= w_idx_nxt;
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_count      <= w_count_nxt;
            r_ready      <= w_ready_nxt;
            r_full       <= w_full_nxt;
            r_overflow   <= r_overflow | w_drop;
            r_strobe_out <= w_pop;
            if (w_pop) begin
                r_data_out <= r_mem_data[r_rptr];
                r_byte_cnt <= r_mem_cnt[r_rptr];
                r_last_out <= r_mem_last[r_rptr];
            end
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_word;
            r_mem_cnt[r_wptr]  <= w_word_cnt;
            r_mem_last[r_wptr] <= bus.data_end;
        end
    end

    assign bus.full       = r_full;
    assign bus.overflow   = r_overflow;
    assign bus.ready      = r_ready;
    assign bus.strobe_out = r_strobe_out;
    assign bus.data_out   = r_data_out;
    assign bus.byte_cnt   = r_byte_cnt;
    assign bus.last_out   = r_last_out;

endmodule
